// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a five-stage pipeline.
//
// Drives the PC write enable and the writeEN/flush pair of each pipeline
// register (IF/ID, ID/EX, EX/MEM, MEM/WB). A register with flush=1 loads a
// bubble; writeEN=0 holds its contents. A small FSM tracks outstanding data
// accesses (DWAIT), the drain that follows a halt reaching MEM (DRAIN), and
// the terminal HALTED state.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit, dhit           instruction fetch / data access complete
//   exmem_dREN/dWEN      load / store currently in MEM
//   idex_MemRead         load currently in EX
//   idex_writeReg[4:0]   EX destination register
//   ifid_rs/rt[4:0]      ID source registers
//   exmem_branch_taken   branch/jump resolved taken in MEM
//   exmem_halt           halt in MEM
//   memwb_halt           halt in WB
//   pc_writeEN           PC update enable
//   *_writeEN, *_flush   per-register advance / bubble controls
//   halt                 registered halt indication
//   stall_cnt[15:0]      saturating count of cycles with the PC frozen
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_writeReg,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        exmem_branch_taken,
  input  logic        exmem_halt,
  input  logic        memwb_halt,
  output logic        pc_writeEN,
  output logic        ifid_writeEN,
  output logic        ifid_flush,
  output logic        idex_writeEN,
  output logic        idex_flush,
  output logic        exmem_writeEN,
  output logic        exmem_flush,
  output logic        memwb_writeEN,
  output logic        memwb_flush,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic dreq, data_stall, loaduse;
  logic pc_we;
  logic ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl;

  assign dreq       = exmem_dREN | exmem_dWEN;
  assign data_stall = dreq & ~dhit;
  // x0 is hardwired, so a load targeting it never creates a real dependency.
  assign loaduse    = idex_MemRead & (idex_writeReg != 5'd0) &
                      ((idex_writeReg == ifid_rs) | (idex_writeReg == ifid_rt));

  // Pipeline-register controls, highest-priority condition first.
  // NOTE: every output is given a default before the if-chain so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    exmem_we = 1'b1;
    memwb_we = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    memwb_fl = 1'b0;

    if (!nRST) begin
      // Hold everything as bubbles while reset is applied.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
      memwb_fl = 1'b1;
    end else if (state_q == HALTED) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (data_stall) begin
      // Freeze the whole pipe until the data access completes.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (state_q == DRAIN) begin
      // Stop fetching and let the halt and older instructions retire.
      pc_we    = 1'b0;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
    end else if (exmem_branch_taken) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
    end else if (loaduse) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_fl  = 1'b1;
    end else if (!ihit) begin
      pc_we    = 1'b0;
      ifid_fl  = 1'b1;
    end
  end

  // A flushed register must not also be written; flush wins.
  assign pc_writeEN    = pc_we;
  assign ifid_writeEN  = ifid_we  & ~ifid_fl;
  assign idex_writeEN  = idex_we  & ~idex_fl;
  assign exmem_writeEN = exmem_we & ~exmem_fl;
  assign memwb_writeEN = memwb_we & ~memwb_fl;
  assign ifid_flush    = ifid_fl;
  assign idex_flush    = idex_fl;
  assign exmem_flush   = exmem_fl;
  assign memwb_flush   = memwb_fl;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (data_stall)      state_d = DWAIT;
        else if (exmem_halt) state_d = DRAIN;
      end
      DWAIT: begin
        if (data_stall)      state_d = DWAIT;
        else if (exmem_halt) state_d = DRAIN;
        else                 state_d = RUN;
      end
      DRAIN:   state_d = DRAIN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    // A halt reaching WB ends execution from any state.
    if (memwb_halt) state_d = HALTED;
  end

  assign halt_d = halt_q | memwb_halt;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (state_q != HALTED) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Inputs change 1 time unit after a
// rising edge and outputs are sampled 1 time unit later, well away from the
// next edge. Control outputs are compared as a packed 9-bit vector:
// {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, exmem_fl, memwb_we, memwb_fl}.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, exmem_dREN, exmem_dWEN, idex_MemRead;
  logic [4:0]  idex_writeReg, ifid_rs, ifid_rt;
  logic        exmem_branch_taken, exmem_halt, memwb_halt;
  logic        pc_writeEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush;
  logic        exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush;
  logic        halt;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] C_DEFAULT = 9'b1_10_10_10_10;
  localparam logic [8:0] C_STALL   = 9'b0_00_00_00_00;
  localparam logic [8:0] C_RESET   = 9'b0_01_01_01_01;
  localparam logic [8:0] C_LOADUSE = 9'b0_00_01_10_10;
  localparam logic [8:0] C_BRANCH  = 9'b1_01_01_01_10;
  localparam logic [8:0] C_FMISS   = 9'b0_01_10_10_10;
  localparam logic [8:0] C_DRAIN   = 9'b0_01_01_10_10;
  localparam logic [8:0] C_HALTED  = 9'b0_00_00_00_00;

  localparam logic [1:0] S_RUN = 2'd0, S_DWAIT = 2'd1, S_DRAIN = 2'd2, S_HALTED = 2'd3;

  logic [8:0] ctl;
  logic [1:0] st;
  assign ctl = {pc_writeEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
                exmem_writeEN, exmem_flush, memwb_writeEN, memwb_flush};
  assign st  = dut.state_q;

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .idex_MemRead(idex_MemRead), .idex_writeReg(idex_writeReg),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_branch_taken(exmem_branch_taken),
    .exmem_halt(exmem_halt), .memwb_halt(memwb_halt),
    .pc_writeEN(pc_writeEN),
    .ifid_writeEN(ifid_writeEN), .ifid_flush(ifid_flush),
    .idex_writeEN(idex_writeEN), .idex_flush(idex_flush),
    .exmem_writeEN(exmem_writeEN), .exmem_flush(exmem_flush),
    .memwb_writeEN(memwb_writeEN), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    idex_MemRead = 1'b0; idex_writeReg = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    exmem_branch_taken = 1'b0; exmem_halt = 1'b0; memwb_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    #3;
    check("reset_ctl", 32'(ctl), 32'(C_RESET));
    check("reset_halt", 32'(halt), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    check("reset_state", 32'(st), 32'(S_RUN));

    tick();
    nRST = 1'b1;
    #1;
    check("idle_ctl", 32'(ctl), 32'(C_DEFAULT));

    // Data miss for three cycles, hit on the fourth.
    tick();
    exmem_dREN = 1'b1; dhit = 1'b0;
    #1;
    check("dmiss1_ctl", 32'(ctl), 32'(C_STALL));
    check("dmiss1_state", 32'(st), 32'(S_RUN));
    tick(); #1;
    check("dmiss2_ctl", 32'(ctl), 32'(C_STALL));
    check("dmiss2_state", 32'(st), 32'(S_DWAIT));
    check("dmiss2_cnt", 32'(stall_cnt), 32'd1);
    tick(); #1;
    check("dmiss3_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    dhit = 1'b1;
    #1;
    check("dhit_state", 32'(st), 32'(S_DWAIT));
    check("dhit_cnt", 32'(stall_cnt), 32'd3);
    check("dhit_ctl", 32'(ctl), 32'(C_DEFAULT));
    tick();
    idle(); exmem_dWEN = 1'b1; dhit = 1'b1;
    #1;
    check("dwait_exit_state", 32'(st), 32'(S_RUN));
    check("store_hit_ctl", 32'(ctl), 32'(C_DEFAULT));
    tick();
    idle();
    #1;
    check("store_hit_state", 32'(st), 32'(S_RUN));
    check("store_hit_cnt", 32'(stall_cnt), 32'd3);

    // Load-use on rt, then the same with x0 as destination, then on rs.
    idex_MemRead = 1'b1; idex_writeReg = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd2;
    #1;
    check("loaduse_rt_ctl", 32'(ctl), 32'(C_LOADUSE));
    tick();
    idex_writeReg = 5'd0; ifid_rt = 5'd0;
    #1;
    check("loaduse_cnt", 32'(stall_cnt), 32'd4);
    check("loaduse_x0_ctl", 32'(ctl), 32'(C_DEFAULT));
    idex_writeReg = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd3;
    #1;
    check("loaduse_rs_ctl", 32'(ctl), 32'(C_LOADUSE));
    idex_MemRead = 1'b0;
    #1;
    check("no_memread_ctl", 32'(ctl), 32'(C_DEFAULT));

    // Branch beats load-use.
    idex_MemRead = 1'b1; exmem_branch_taken = 1'b1;
    #1;
    check("branch_over_lu_ctl", 32'(ctl), 32'(C_BRANCH));
    tick();
    idle(); ihit = 1'b0;
    #1;
    check("branch_cnt", 32'(stall_cnt), 32'd4);
    check("fetch_miss_ctl", 32'(ctl), 32'(C_FMISS));
    tick();
    idle(); exmem_dREN = 1'b1; exmem_branch_taken = 1'b1;
    #1;
    check("fmiss_cnt", 32'(stall_cnt), 32'd5);
    check("stall_over_branch_ctl", 32'(ctl), 32'(C_STALL));

    // Reset pulse in the middle of DWAIT.
    tick();
    check("pre_reset_state", 32'(st), 32'(S_DWAIT));
    nRST = 1'b0;
    #1;
    check("midreset_state", 32'(st), 32'(S_RUN));
    check("midreset_cnt", 32'(stall_cnt), 32'd0);
    check("midreset_halt", 32'(halt), 32'd0);
    check("midreset_ctl", 32'(ctl), 32'(C_RESET));
    idle();
    #1;
    nRST = 1'b1;
    #1;
    check("post_reset_ctl", 32'(ctl), 32'(C_DEFAULT));

    // Halt in MEM, then in WB on the next cycle.
    tick();
    exmem_halt = 1'b1;
    #1;
    check("exmem_halt_ctl", 32'(ctl), 32'(C_DEFAULT));
    tick();
    idle(); memwb_halt = 1'b1;
    #1;
    check("drain_state", 32'(st), 32'(S_DRAIN));
    check("drain_ctl", 32'(ctl), 32'(C_DRAIN));
    check("drain_halt", 32'(halt), 32'd0);
    tick();
    idle();
    #1;
    check("halted_halt", 32'(halt), 32'd1);
    check("halted_cnt", 32'(stall_cnt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; exmem_dREN = i[1]; exmem_branch_taken = i[2];
      #1;
      check("halted_ctl", 32'(ctl), 32'(C_HALTED));
      check("halted_state", 32'(st), 32'(S_HALTED));
      tick();
    end
    check("halted_hold_halt", 32'(halt), 32'd1);
    check("halted_hold_cnt", 32'(stall_cnt), 32'd1);

    // Long fetch miss to exercise saturation.
    nRST = 1'b0;
    idle();
    #1;
    nRST = 1'b1;
    tick();
    ihit = 1'b0;
    repeat (65534) @(posedge CLK);
    #1;
    check("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
    @(posedge CLK);
    #1;
    check("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
    repeat (4465) @(posedge CLK);
    #1;
    check("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
    check("sat_halt", 32'(halt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL use reset nRST, asynchronous, active-low; clock CLK.
REQ-002 SHALL have ports (name direction width meaning):
 CLK in 1 clock; nRST in 1 async active-low reset;
 ihit in 1 instruction fetch complete; dhit in 1 data access complete;
 exmem_dREN in 1 load in MEM; exmem_dWEN in 1 store in MEM;
 idex_MemRead in 1 load in EX; idex_writeReg in 5 EX destination reg;
 ifid_rs in 5, ifid_rt in 5 ID source regs;
 exmem_branch_taken in 1 branch/jump resolved taken in MEM;
 exmem_halt in 1 halt in MEM; memwb_halt in 1 halt in WB;
 pc_writeEN out 1; ifid_writeEN/ifid_flush out 1 each;
 idex_writeEN/idex_flush out 1 each; exmem_writeEN/exmem_flush out 1 each;
 memwb_writeEN/memwb_flush out 1 each;
 halt out 1 registered halt; stall_cnt out 16 saturating stall-cycle count.
REQ-003 SHALL drive writeEN/flush pairs to the four pipeline registers; a register with flush=1 clears to a bubble; writeEN=0 holds it.

Function
REQ-004 SHALL implement FSM states RUN, DWAIT, DRAIN, HALTED, 2-bit registered.
REQ-005 SHALL define dreq = exmem_dREN | exmem_dWEN.
REQ-006 SHALL define loaduse = idex_MemRead & (idex_writeReg != 0) & (idex_writeReg == ifid_rs | idex_writeReg == ifid_rt).
REQ-007 Default (no condition active): all writeEN=1, all flush=0, pc_writeEN=1.
REQ-008 Priority, highest first: HALTED, data stall, DRAIN, branch, load-use, fetch miss.
REQ-009 Data stall (RUN or DWAIT, dreq & !dhit): pc and all four writeEN=0, all flush=0.
REQ-010 RUN -> DWAIT when dreq & !dhit; DWAIT -> RUN in the cycle dhit=1, that cycle uses non-stall outputs.
REQ-011 dreq & dhit in RUN SHALL advance with zero stall cycles, no state change.
REQ-012 Branch (exmem_branch_taken, no data stall): ifid_flush, idex_flush, exmem_flush=1; pc_writeEN=1; memwb_writeEN=1.
REQ-013 Load-use (no branch, no data stall): pc_writeEN=0, ifid_writeEN=0, idex_flush=1; exmem/memwb writeEN=1.
REQ-014 Fetch miss (!ihit, none above): pc_writeEN=0, ifid_flush=1, other stages advance.
REQ-015 RUN/DWAIT -> DRAIN when exmem_halt=1 and no data stall; DRAIN: pc_writeEN=0, ifid_flush=1, idex_flush=1, exmem/memwb writeEN=1 (data stall still overrides).
REQ-016 Any state -> HALTED when memwb_halt=1; halt register set on that edge.
REQ-017 HALTED: all writeEN=0, all flush=0, pc_writeEN=0, halt=1; exits only on reset.
REQ-018 A writeEN and its flush SHALL never both be 1; flush dominates if asserted.
REQ-019 stall_cnt SHALL increment each cycle pc_writeEN=0 and state != HALTED; saturate at 16'hFFFF.
REQ-020 Load-use with idex_writeReg=0 SHALL NOT stall.
REQ-021 Outputs except halt and stall_cnt SHALL be combinational from state and inputs.

Reset
REQ-022 nRST low SHALL asynchronously force state=RUN, halt=0, stall_cnt=0.
REQ-023 During reset, all writeEN=0, all flush=1, pc_writeEN=0.
REQ-024 Reset asserted mid-DWAIT or mid-DRAIN SHALL return to RUN with no residual stall.

Verification
REQ-025 Bench SHALL cover:
 - dreq=1, dhit=0 for 3 cycles then 1 -> all writeEN=0 for 3 cycles, state DWAIT, stall_cnt=3, advance on 4th.
 - idex_MemRead=1, idex_writeReg=5, ifid_rt=5 -> pc/ifid writeEN=0, idex_flush=1 one cycle; repeat with writeReg=0 -> no stall.
 - exmem_branch_taken=1 with loaduse=1 -> branch flushes win: ifid/idex/exmem_flush=1, pc_writeEN=1.
 - exmem_halt=1 then memwb_halt=1 next cycle -> DRAIN then HALTED, halt=1, all writeEN=0, held 10 cycles.
 - Stall 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
 - nRST pulse during DWAIT -> state RUN, stall_cnt=0, halt=0 immediately.
